// File: rtl/lte_sym_framer.sv
// LTE OFDM symbol framer: tags each input sample with symbol start, slot start and symbol index.
// Latency: 1 clock from the Src_v cycle to Dout_*.
// Backpressure: none; one output strobe is produced for every accepted Src_v sample.
module lte_sym_framer #(
  parameter int BIT_WIDTH    = 16,
  parameter int CLK_FS_RATIO = 5
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [1:0]           FFT_num,
  input  logic                 CP_type,
  input  logic [BIT_WIDTH-1:0] Src_i,
  input  logic [BIT_WIDTH-1:0] Src_q,
  input  logic                 Src_v,
  input  logic                 Slot_sync,
  output logic [BIT_WIDTH-1:0] Dout_i,
  output logic [BIT_WIDTH-1:0] Dout_q,
  output logic                 Dout_v,
  output logic                 Dout_h,
  output logic                 Dout_s,
  output logic [2:0]           Sym_idx,
  output logic                 Sync_err
);

  // The sample-rate ratio only describes the expected Src_v cadence; framing counts samples.
  if (CLK_FS_RATIO < 5 || CLK_FS_RATIO > 6) begin : g_bad_ratio
    $error("lte_sym_framer: CLK_FS_RATIO must be 5 or 6");
  end

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               state_q;
  logic [1:0]           rst_sync_q;
  logic [11:0]          samp_q;
  logic [2:0]           sym_q;
  logic [1:0]           fft_q;
  logic                 ext_q;
  logic [BIT_WIDTH-1:0] dout_i_q, dout_q_q;
  logic                 dout_v_q, dout_h_q, dout_s_q, sync_err_q;
  logic [2:0]           sym_idx_q;

  logic                 take, start, resync, at_slot_edge, samp_wrap;
  logic [1:0]           cfg_fft;
  logic                 cfg_ext;
  logic [2:0]           pos_sym, last_sym, sym_d;
  logic [11:0]          pos_samp, n_len, cp_len, sym_len, samp_d;

  // Release of reset is re-timed so the FSM never starts on a half-released reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  // Position of the current sample and the next position, with slot-start/resync handling.
  always_comb begin
    at_slot_edge = (sym_q == 3'd0) && (samp_q == 12'd0);
    take         = Src_v && ((state_q == RUN) || (Slot_sync && rst_sync_q[1]));
    start        = take && (at_slot_edge || Slot_sync);
    resync       = take && Slot_sync && (state_q == RUN) && !at_slot_edge;
    cfg_fft      = fft_q;
    cfg_ext      = ext_q;
    pos_sym      = sym_q;
    pos_samp     = samp_q;
    if (start) begin
      // Configuration is only sampled at a slot boundary (natural wrap or forced restart).
      cfg_fft  = FFT_num;
      cfg_ext  = CP_type;
      pos_sym  = 3'd0;
      pos_samp = 12'd0;
    end
    n_len  = 12'd2048;
    cp_len = 12'd160;
    case (cfg_fft)
      2'd0: begin n_len = 12'd2048; cp_len = cfg_ext ? 12'd512 : ((pos_sym == 3'd0) ? 12'd160 : 12'd144); end
      2'd1: begin n_len = 12'd1536; cp_len = cfg_ext ? 12'd384 : ((pos_sym == 3'd0) ? 12'd120 : 12'd108); end
      2'd2: begin n_len = 12'd1024; cp_len = cfg_ext ? 12'd256 : ((pos_sym == 3'd0) ? 12'd80  : 12'd72);  end
      default: begin n_len = 12'd512; cp_len = cfg_ext ? 12'd128 : ((pos_sym == 3'd0) ? 12'd40  : 12'd36);  end
    endcase
    sym_len   = n_len + cp_len;
    last_sym  = cfg_ext ? 3'd5 : 3'd6;
    samp_wrap = (pos_samp == sym_len - 12'd1);
    samp_d    = samp_wrap ? 12'd0 : pos_samp + 12'd1;
    sym_d     = pos_sym;
    if (samp_wrap) sym_d = (pos_sym == last_sym) ? 3'd0 : pos_sym + 3'd1;
  end

  // Framing FSM with registered outputs; strobes default low, data holds between samples.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      samp_q     <= 12'd0;
      sym_q      <= 3'd0;
      fft_q      <= 2'd0;
      ext_q      <= 1'b0;
      dout_i_q   <= '0;
      dout_q_q   <= '0;
      dout_v_q   <= 1'b0;
      dout_h_q   <= 1'b0;
      dout_s_q   <= 1'b0;
      sym_idx_q  <= 3'd0;
      sync_err_q <= 1'b0;
    end else begin
      dout_v_q   <= 1'b0;
      dout_h_q   <= 1'b0;
      dout_s_q   <= 1'b0;
      sync_err_q <= 1'b0;
      if (take) begin
        state_q    <= RUN;
        dout_i_q   <= Src_i;
        dout_q_q   <= Src_q;
        dout_v_q   <= 1'b1;
        dout_h_q   <= (pos_samp == 12'd0);
        dout_s_q   <= (pos_samp == 12'd0) && (pos_sym == 3'd0);
        sym_idx_q  <= pos_sym;
        sync_err_q <= resync;
        fft_q      <= cfg_fft;
        ext_q      <= cfg_ext;
        samp_q     <= samp_d;
        sym_q      <= sym_d;
      end
    end
  end

  assign Dout_i   = dout_i_q;
  assign Dout_q   = dout_q_q;
  assign Dout_v   = dout_v_q;
  assign Dout_h   = dout_h_q;
  assign Dout_s   = dout_s_q;
  assign Sym_idx  = sym_idx_q;
  assign Sync_err = sync_err_q;

endmodule

// File: tb/tb_lte_sym_framer.sv
// Testbench for lte_sym_framer: random sample data, slot-position reference model.
// Outputs are sampled 1 time unit after each rising edge.
// No backpressure exists; every cycle's outputs are compared against the model.
module tb_lte_sym_framer;
  localparam int BW = 16;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic [1:0]    FFT_num = 2'd0;
  logic          CP_type = 1'b0;
  logic [BW-1:0] Src_i = '0, Src_q = '0;
  logic          Src_v = 1'b0, Slot_sync = 1'b0;
  logic [BW-1:0] Dout_i, Dout_q;
  logic          Dout_v, Dout_h, Dout_s, Sync_err;
  logic [2:0]    Sym_idx;

  int n_cmp = 0;
  int n_err = 0;

  lte_sym_framer #(.BIT_WIDTH(BW), .CLK_FS_RATIO(5)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .FFT_num(FFT_num), .CP_type(CP_type),
    .Src_i(Src_i), .Src_q(Src_q), .Src_v(Src_v), .Slot_sync(Slot_sync),
    .Dout_i(Dout_i), .Dout_q(Dout_q), .Dout_v(Dout_v), .Dout_h(Dout_h),
    .Dout_s(Dout_s), .Sym_idx(Sym_idx), .Sync_err(Sync_err)
  );

  always #5 Clk = ~Clk;

  // Reference model: absolute sample offset inside the slot plus latched configuration.
  bit            m_run;
  int            m_k, m_fft;
  bit            m_ext;
  bit            e_v, e_h, e_s, e_err;
  logic [2:0]    e_idx;
  logic [BW-1:0] e_i, e_q;

  function automatic int sym_len(int fft, bit ext, int s);
    int n;
    n = 2048 - 512 * fft;
    if (ext) return n + n / 4;
    if (s == 0) return n + n * 5 / 64;
    return n + n * 9 / 128;
  endfunction

  function automatic logic [38:0] exp_vec();
    return {e_v, e_h, e_s, e_idx, e_err, e_i, e_q};
  endfunction

  function automatic logic [38:0] dut_vec();
    return {Dout_v, Dout_h, Dout_s, Sym_idx, Sync_err, Dout_i, Dout_q};
  endfunction

  task automatic model_reset();
    m_run = 0; m_k = 0; m_fft = 0; m_ext = 0;
    e_v = 0; e_h = 0; e_s = 0; e_err = 0; e_idx = '0; e_i = '0; e_q = '0;
  endtask

  task automatic model_sample(input bit v, input bit sync);
    bit emit, start, err;
    int acc, len, nsym;
    e_v = 0; e_h = 0; e_s = 0; e_err = 0;
    if (!v) return;
    if (!m_run) begin emit = sync; start = sync; err = 0; end
    else begin emit = 1; start = (m_k == 0) || sync; err = sync && (m_k != 0); end
    if (!emit) return;
    m_run = 1;
    if (start) begin m_k = 0; m_fft = int'(FFT_num); m_ext = CP_type; end
    nsym = m_ext ? 6 : 7;
    acc = 0;
    for (int s = 0; s < nsym; s++) begin
      len = sym_len(m_fft, m_ext, s);
      if (m_k >= acc && m_k < acc + len) begin e_idx = 3'(s); e_h = (m_k == acc); end
      acc += len;
    end
    e_s = (m_k == 0); e_v = 1; e_err = err; e_i = Src_i; e_q = Src_q;
    m_k = (m_k + 1) % acc;
  endtask

  // One clock of stimulus; returns 1 time unit after the capturing edge.
  task automatic drive(input bit v, input bit sync);
    Src_v = v; Slot_sync = sync;
    if (v) begin Src_i = BW'($urandom); Src_q = BW'($urandom); end
    model_sample(v, sync);
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    Src_v = 0; Slot_sync = 0; Reset_n = 0; #1;
    model_reset();
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1;
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset_n = 0; #2;
    model_reset();
    n_cmp++; if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL reset_state out=%h exp=%h", dut_vec(), exp_vec()); end
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1;
    for (int k = 0; k < 20; k++) begin
      drive(k % 2 == 0, k % 2 == 1);
      n_cmp++; if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL idle_wait k=%0d out=%h exp=%h", k, dut_vec(), exp_vec()); end
    end
    drive(1, 1);
    n_cmp++; if ({Dout_v, Dout_h, Dout_s, Sym_idx} !== 6'b111_000) begin n_err++; $display("FAIL idle_start out=%b exp=111000", {Dout_v, Dout_h, Dout_s, Sym_idx}); end
  endtask

  task automatic test_normal_2048();
    int hq[$]; int sq[$]; int maxi;
    int exp_h[8] = '{0, 2208, 4400, 6592, 8784, 10976, 13168, 15360};
    do_reset(); FFT_num = 0; CP_type = 0; maxi = 0;
    for (int k = 0; k <= 15360; k++) begin
      drive(1, k == 0);
      n_cmp++; if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL normal k=%0d out=%h exp=%h", k, dut_vec(), exp_vec()); end
      if (Dout_v && Dout_h) hq.push_back(k);
      if (Dout_v && Dout_s) sq.push_back(k);
      if (Dout_v && int'(Sym_idx) > maxi) maxi = int'(Sym_idx);
      if (k < 40) repeat (4) begin
        drive(0, 0);
        n_cmp++; if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL normal_gap k=%0d out=%h exp=%h", k, dut_vec(), exp_vec()); end
      end
    end
    n_cmp++; if (hq.size() != 8) begin n_err++; $display("FAIL normal_hcount got=%0d exp=8", hq.size()); end
    else for (int j = 0; j < 8; j++) begin
      n_cmp++; if (hq[j] != exp_h[j]) begin n_err++; $display("FAIL normal_hpos j=%0d got=%0d exp=%0d", j, hq[j], exp_h[j]); end
    end
    n_cmp++; if (sq.size() != 2 || sq[0] != 0 || sq[sq.size()-1] != 15360) begin n_err++; $display("FAIL normal_spos got_n=%0d exp=2 (0,15360)", sq.size()); end
    n_cmp++; if (maxi != 6) begin n_err++; $display("FAIL normal_maxidx got=%0d exp=6", maxi); end
  endtask

  task automatic test_ext_512();
    int hq[$]; int sq[$]; int maxi;
    do_reset(); FFT_num = 3; CP_type = 1; maxi = 0;
    for (int k = 0; k <= 7680; k++) begin
      drive(1, k == 0);
      n_cmp++; if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL ext k=%0d out=%h exp=%h", k, dut_vec(), exp_vec()); end
      if (Dout_v && Dout_h) hq.push_back(k);
      if (Dout_v && Dout_s) sq.push_back(k);
      if (Dout_v && int'(Sym_idx) > maxi) maxi = int'(Sym_idx);
    end
    n_cmp++; if (hq.size() != 13) begin n_err++; $display("FAIL ext_hcount got=%0d exp=13", hq.size()); end
    else for (int j = 0; j < 13; j++) begin
      n_cmp++; if (hq[j] != 640 * j) begin n_err++; $display("FAIL ext_hpos j=%0d got=%0d exp=%0d", j, hq[j], 640 * j); end
    end
    n_cmp++; if (sq.size() != 3 || sq[1] != 3840 || sq[2] != 7680) begin n_err++; $display("FAIL ext_spos got_n=%0d exp=3 (0,3840,7680)", sq.size()); end
    n_cmp++; if (maxi != 5) begin n_err++; $display("FAIL ext_maxidx got=%0d exp=5", maxi); end
  endtask

  task automatic test_sync_err();
    int eq[$]; int hq[$];
    do_reset(); FFT_num = 0; CP_type = 0;
    for (int k = 0; k <= 7300; k++) begin
      drive(1, k == 0 || k == 5000);
      n_cmp++; if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL syncerr k=%0d out=%h exp=%h", k, dut_vec(), exp_vec()); end
      if (Sync_err) eq.push_back(k);
      if (Dout_v && Dout_h && k >= 5000) hq.push_back(k);
      if (k == 5000) begin
        n_cmp++; if ({Dout_h, Dout_s, Sym_idx} !== 5'b11_000) begin n_err++; $display("FAIL syncerr_restart out=%b exp=11000", {Dout_h, Dout_s, Sym_idx}); end
      end
    end
    n_cmp++; if (eq.size() != 1 || eq[0] != 5000) begin n_err++; $display("FAIL syncerr_pulse got_n=%0d exp=1 at 5000", eq.size()); end
    n_cmp++; if (hq.size() < 2 || hq[1] != 7208) begin n_err++; $display("FAIL syncerr_nexth got_n=%0d exp second h at 7208", hq.size()); end
  endtask

  task automatic test_cfg_change();
    int hq[$]; int sq[$];
    int exp_h[15] = '{0, 2208, 4400, 6592, 8784, 10976, 13168, 15360,
                      16464, 17560, 18656, 19752, 20848, 21944, 23040};
    do_reset(); FFT_num = 0; CP_type = 0;
    for (int k = 0; k <= 23040; k++) begin
      FFT_num = (k >= 3000) ? 2'd2 : 2'd0;
      drive(1, k == 0);
      n_cmp++; if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL cfg k=%0d out=%h exp=%h", k, dut_vec(), exp_vec()); end
      if (Dout_v && Dout_h) hq.push_back(k);
      if (Dout_v && Dout_s) sq.push_back(k);
    end
    n_cmp++; if (hq.size() != 15) begin n_err++; $display("FAIL cfg_hcount got=%0d exp=15", hq.size()); end
    else for (int j = 0; j < 15; j++) begin
      n_cmp++; if (hq[j] != exp_h[j]) begin n_err++; $display("FAIL cfg_hpos j=%0d got=%0d exp=%0d", j, hq[j], exp_h[j]); end
    end
    n_cmp++; if (sq.size() != 3 || sq[1] != 15360 || sq[2] != 23040) begin n_err++; $display("FAIL cfg_spos got_n=%0d exp=3 (0,15360,23040)", sq.size()); end
  endtask

  task automatic test_reset_mid();
    int nv;
    do_reset(); FFT_num = 0; CP_type = 0; nv = 0;
    for (int k = 0; k <= 7000; k++) begin
      drive(1, k == 0);
      n_cmp++; if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL rstmid k=%0d out=%h exp=%h", k, dut_vec(), exp_vec()); end
    end
    Reset_n = 0; #1;
    model_reset();
    n_cmp++; if (dut_vec() !== 39'd0) begin n_err++; $display("FAIL rstmid_async out=%h exp=0", dut_vec()); end
    repeat (2) begin
      Src_v = 1; Src_i = BW'($urandom); @(posedge Clk); #1;
      n_cmp++; if (dut_vec() !== 39'd0) begin n_err++; $display("FAIL rstmid_hold out=%h exp=0", dut_vec()); end
    end
    Reset_n = 1;
    for (int k = 0; k < 30; k++) begin
      drive(1, 0);
      if (Dout_v) nv++;
    end
    n_cmp++; if (nv != 0) begin n_err++; $display("FAIL rstmid_nov got=%0d valid exp=0", nv); end
    drive(1, 1);
    n_cmp++; if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL rstmid_restart out=%h exp=%h", dut_vec(), exp_vec()); end
  endtask

  task automatic test_irregular();
    int hq[$]; int gap;
    do_reset(); FFT_num = 3; CP_type = 0;
    for (int k = 0; k <= 1100; k++) begin
      drive(1, k == 0);
      n_cmp++; if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL irreg k=%0d out=%h exp=%h", k, dut_vec(), exp_vec()); end
      if (Dout_v && Dout_h) hq.push_back(k);
      gap = $urandom_range(19, 5);
      repeat (gap) begin
        drive(0, $urandom_range(3, 0) == 0);
        n_cmp++; if (dut_vec() !== exp_vec()) begin n_err++; $display("FAIL irreg_gap k=%0d out=%h exp=%h", k, dut_vec(), exp_vec()); end
      end
    end
    n_cmp++; if (hq.size() != 3 || hq[1] != 552 || hq[2] != 1100) begin n_err++; $display("FAIL irreg_hpos got_n=%0d exp=3 (0,552,1100)", hq.size()); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_normal_2048();
    test_ext_512();
    test_sync_err();
    test_cfg_change();
    test_reset_mid();
    test_irregular();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
